// File: rtl/decode_stage.sv
// RV32I decode stage with a 2-entry skid buffer between the instruction register and the ALU/register file.
// Optional feature: define DECODE_ILLEGAL_EN to add the illegal_o flag for unmapped opcodes.
`ifndef RTYPE
`define RTYPE 5'b00001
`endif
`ifndef ITYPE
`define ITYPE 5'b00010
`endif
`ifndef STYPE
`define STYPE 5'b00100
`endif
`ifndef UTYPE
`define UTYPE 5'b01000
`endif
`ifndef HOLD
`define HOLD  5'b10000
`endif

module decode_stage #(
    parameter int XLEN    = 32,
    parameter int ITYPE_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        ir_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ITYPE_W-1:0] itype_o,
    output logic [6:0]         opcode_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic [2:0]         funct3_o,
    output logic [6:0]         funct7_o,
    output logic [XLEN-1:0]    imm_o,
    output logic [XLEN-1:0]    pc_o
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic               illegal_o
`endif
);

    typedef struct packed {
        logic [ITYPE_W-1:0] itype;
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
`ifdef DECODE_ILLEGAL_EN
        logic               illegal;
`endif
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state;
    entry_t main_q, skid_q, dec;
    logic   in_fire, out_fire;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    // Pure function of the incoming word; unused fields stay zero.
    always_comb begin
        dec       = '0;
        dec.pc    = pc_i;
        dec.itype = `HOLD;
        case (ir_i[6:0])
            7'b0110011: begin
                dec.itype  = `RTYPE;
                dec.rd     = ir_i[11:7];
                dec.rs1    = ir_i[19:15];
                dec.rs2    = ir_i[24:20];
                dec.funct3 = ir_i[14:12];
                dec.funct7 = ir_i[31:25];
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.itype  = `ITYPE;
                dec.rd     = ir_i[11:7];
                dec.rs1    = ir_i[19:15];
                dec.funct3 = ir_i[14:12];
                dec.imm    = {{20{ir_i[31]}}, ir_i[31:20]};
            end
            7'b0100011: begin
                dec.itype  = `STYPE;
                dec.rs1    = ir_i[19:15];
                dec.rs2    = ir_i[24:20];
                dec.funct3 = ir_i[14:12];
                dec.imm    = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            end
            7'b1100011: begin
                dec.itype  = `STYPE;
                dec.rs1    = ir_i[19:15];
                dec.rs2    = ir_i[24:20];
                dec.funct3 = ir_i[14:12];
                dec.imm    = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.itype  = `UTYPE;
                dec.rd     = ir_i[11:7];
                dec.imm    = {ir_i[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.itype  = `UTYPE;
                dec.rd     = ir_i[11:7];
                dec.imm    = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            end
            default: ;
        endcase
        if (dec.itype != `HOLD)
            dec.opcode = ir_i[6:0];
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = (dec.itype == `HOLD) || (ir_i[1:0] != 2'b11);
`endif
    end

    // FULL never sees in_fire because in_ready_o is low there.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= EMPTY;
            out_valid_o  <= 1'b0;
            in_ready_o   <= 1'b1;
            main_q       <= '0;
            main_q.itype <= `HOLD;
            skid_q       <= '0;
        end else if (flush_i) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q      <= dec;
                        state       <= ONE;
                        out_valid_o <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= dec;
                    end else if (in_fire) begin
                        skid_q     <= dec;
                        state      <= FULL;
                        in_ready_o <= 1'b0;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_o <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state      <= ONE;
                        in_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                end
            endcase
        end
    end

    assign itype_o  = main_q.itype;
    assign opcode_o = main_q.opcode;
    assign rd_o     = main_q.rd;
    assign rs1_o    = main_q.rs1;
    assign rs2_o    = main_q.rs2;
    assign funct3_o = main_q.funct3;
    assign funct7_o = main_q.funct7;
    assign imm_o    = main_q.imm;
    assign pc_o     = main_q.pc;
`ifdef DECODE_ILLEGAL_EN
    assign illegal_o = main_q.illegal & out_valid_o;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: field decode, skid backpressure, flush and reset.
`ifndef RTYPE
`define RTYPE 5'b00001
`endif
`ifndef ITYPE
`define ITYPE 5'b00010
`endif
`ifndef STYPE
`define STYPE 5'b00100
`endif
`ifndef UTYPE
`define UTYPE 5'b01000
`endif
`ifndef HOLD
`define HOLD  5'b10000
`endif

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_i, in_ready_o;
    logic [31:0] ir_i, pc_i;
    logic        flush_i;
    logic        out_valid_o, out_ready_i;
    logic [4:0]  itype_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [31:0] imm_o, pc_o;
`ifdef DECODE_ILLEGAL_EN
    logic        illegal_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .ir_i(ir_i), .pc_i(pc_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .itype_o(itype_o), .opcode_o(opcode_o),
        .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .funct3_o(funct3_o), .funct7_o(funct7_o),
        .imm_o(imm_o), .pc_o(pc_o)
`ifdef DECODE_ILLEGAL_EN
        , .illegal_o(illegal_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single edge with out_ready high, then idle.
    task automatic send(input logic [31:0] ir, input logic [31:0] pc);
        in_valid_i = 1'b1; ir_i = ir; pc_i = pc;
        step();
        in_valid_i = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid_i = 1'b0; ir_i = '0; pc_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b1;
        step(); step();
        check("rst_valid", out_valid_o, 0);
        check("rst_ready", in_ready_o, 1);
        check("rst_itype", itype_o, `HOLD);
        check("rst_imm",   imm_o, 0);
        check("rst_pc",    pc_o, 0);
        reset = 1'b1;
        step();

        // addi x1, x0, -1
        send(32'hFFF00093, 32'h100);
        check("addi_valid", out_valid_o, 1);
        check("addi_itype", itype_o, `ITYPE);
        check("addi_rd",    rd_o, 1);
        check("addi_rs1",   rs1_o, 0);
        check("addi_rs2",   rs2_o, 0);
        check("addi_imm",   imm_o, 32'hFFFFFFFF);
        check("addi_pc",    pc_o, 32'h100);
        check("addi_op",    opcode_o, 7'h13);
        step();
        check("drain_valid", out_valid_o, 0);

        // sw x1, 8(x2): raw rd bits are nonzero and must be suppressed
        send(32'h00112423, 32'h104);
        check("sw_itype", itype_o, `STYPE);
        check("sw_rs1",   rs1_o, 2);
        check("sw_rs2",   rs2_o, 1);
        check("sw_rd",    rd_o, 0);
        check("sw_f3",    funct3_o, 2);
        check("sw_imm",   imm_o, 8);

        // beq back-to-back: ONE with in_fire and out_fire replaces main
        send(32'hFE000EE3, 32'h108);
        check("beq_itype", itype_o, `STYPE);
        check("beq_imm",   imm_o, 32'hFFFFFFFC);
        check("beq_rd",    rd_o, 0);
        check("beq_pc",    pc_o, 32'h108);

        send(32'h123450B7, 32'h10C);
        check("lui_itype", itype_o, `UTYPE);
        check("lui_rd",    rd_o, 1);
        check("lui_imm",   imm_o, 32'h12345000);
        check("lui_rs1",   rs1_o, 0);
        check("lui_f3",    funct3_o, 0);

        send(32'h0080006F, 32'h110);
        check("jal_itype", itype_o, `UTYPE);
        check("jal_imm",   imm_o, 8);
        check("jal_rs2",   rs2_o, 0);

        // sub x3, x1, x2
        send(32'h402081B3, 32'h114);
        check("sub_itype", itype_o, `RTYPE);
        check("sub_rd",    rd_o, 3);
        check("sub_rs1",   rs1_o, 1);
        check("sub_rs2",   rs2_o, 2);
        check("sub_f7",    funct7_o, 7'h20);
        check("sub_imm",   imm_o, 0);

        send(32'hFFFFFFFF, 32'h118);
        check("bad_valid", out_valid_o, 1);
        check("bad_itype", itype_o, `HOLD);
        check("bad_rd",    rd_o, 0);
        check("bad_imm",   imm_o, 0);
`ifdef DECODE_ILLEGAL_EN
        check("bad_ill",   illegal_o, 1);
`endif
        step();
        check("drain2_valid", out_valid_o, 0);

        // Backpressure: A,B fill main+skid, C waits on in_ready
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; ir_i = 32'h00100093; pc_i = 32'h200;
        step();
        check("bp_a_valid", out_valid_o, 1);
        check("bp_a_ready", in_ready_o, 1);
        ir_i = 32'h00200093; pc_i = 32'h204;
        step();
        check("bp_full_ready", in_ready_o, 0);
        check("bp_full_pc",    pc_o, 32'h200);
        ir_i = 32'h00300093; pc_i = 32'h208;
        step();
        check("bp_hold_ready", in_ready_o, 0);
        check("bp_hold_pc",    pc_o, 32'h200);
        check("bp_hold_imm",   imm_o, 1);
        out_ready_i = 1'b1;
        step();
        check("bp_b_pc",  pc_o, 32'h204);
        check("bp_b_imm", imm_o, 2);
        step();
        in_valid_i = 1'b0;
        check("bp_c_pc",  pc_o, 32'h208);
        check("bp_c_imm", imm_o, 3);
        step();
        check("bp_end_valid", out_valid_o, 0);

        // Flush while FULL with a new word offered
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; ir_i = 32'h00100093; pc_i = 32'h300;
        step();
        pc_i = 32'h304;
        step();
        pc_i = 32'h308; flush_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("fl_valid", out_valid_o, 0);
        check("fl_ready", in_ready_o, 1);
        check("fl_itype", itype_o, `ITYPE);
        check("fl_pc",    pc_o, 32'h300);
        out_ready_i = 1'b1;
        step(); step();
        check("fl_never", out_valid_o, 0);

        // Reset while FULL drops both entries
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; ir_i = 32'h00112423; pc_i = 32'h400;
        step();
        pc_i = 32'h404;
        step();
        in_valid_i = 1'b0; reset = 1'b0;
        step();
        check("rf_valid", out_valid_o, 0);
        check("rf_itype", itype_o, `HOLD);
        check("rf_ready", in_ready_o, 1);
        check("rf_pc",    pc_o, 0);
        reset = 1'b1; out_ready_i = 1'b1;
        step();
        check("rf_after", out_valid_o, 0);

`ifdef DECODE_ILLEGAL_EN
        send(32'h0000007F, 32'h500);
        check("ill_flag",  illegal_o, 1);
        check("ill_itype", itype_o, `HOLD);
        send(32'hFFF00093, 32'h504);
        check("ill_clear", illegal_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
